// File: rtl/stage3_packet_seq_ctrl_module.sv
// Stage-3 packet sequencing controller: groups accepted messages into packets and hands
// the (seq, count) pair to the head assembler. Optional idle heartbeat: STAGE3_HEARTBEAT_EN.
module stage3_packet_seq_ctrl_module #(
  parameter int PACKET_SEQ_NUM_DATA_BITS  = 16,
  parameter int PACKET_MESSAGES_DATA_BITS = 8,
  parameter int MAX_MSGS                  = 8,
  parameter int TIMEOUT_CYCLES            = 256,
  parameter int SEQ_INIT                  = 1
) (
  input  logic                                 clk,
  input  logic                                 rst_n,
  input  logic                                 msg_valid,
  output logic                                 msg_ready,
  input  logic                                 flush,
  output logic                                 hdr_valid,
  input  logic                                 hdr_ready,
  output logic [PACKET_SEQ_NUM_DATA_BITS-1:0]  packet_seq_num_data,
  output logic [PACKET_MESSAGES_DATA_BITS-1:0] packet_messages_data
);

  localparam int SW = PACKET_SEQ_NUM_DATA_BITS;
  localparam int MW = PACKET_MESSAGES_DATA_BITS;
  localparam int TW = $clog2(TIMEOUT_CYCLES);

  localparam logic [SW-1:0] SEQ_RST   = SW'(SEQ_INIT);
  localparam logic [SW-1:0] SEQ_ONE   = SW'(1);
  localparam logic [MW-1:0] CNT_ONE   = MW'(1);
  localparam logic [MW-1:0] CNT_MAX   = MW'(MAX_MSGS);
  localparam logic [TW-1:0] TIM_ONE   = TW'(1);
  localparam logic [TW-1:0] TIM_LAST  = TW'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {
    IDLE,
    COLLECT,
    EMIT
  } state_e;

  state_e          state_q, state_d;
  logic [SW-1:0]   seq_q, seq_d;
  logic [MW-1:0]   count_q, count_d;
  logic [TW-1:0]   timer_q, timer_d;
  logic            accept;

`ifdef STAGE3_HEARTBEAT_EN
  logic [TW-1:0]   idle_q, idle_d;
`endif

  // Handshake and header outputs are pure decodes of registered state.
  assign msg_ready            = (state_q != EMIT);
  assign hdr_valid            = (state_q == EMIT);
  assign packet_seq_num_data  = seq_q;
  assign packet_messages_data = count_q;

  assign accept = msg_valid && msg_ready;

  always_comb begin
    // NOTE: every variable gets a default first so no path leaves one unassigned (no latch).
    state_d = state_q;
    seq_d   = seq_q;
    count_d = count_q;
    timer_d = timer_q;
`ifdef STAGE3_HEARTBEAT_EN
    idle_d  = idle_q;
`endif

    case (state_q)
      IDLE: begin
        if (accept) begin
          count_d = CNT_ONE;
          timer_d = '0;
          state_d = (MAX_MSGS == 1 || flush) ? EMIT : COLLECT;
`ifdef STAGE3_HEARTBEAT_EN
          idle_d  = '0;
        end else if (idle_q == TIM_LAST) begin
          // Heartbeat packet: count stays 0, seq is left for the next real packet.
          state_d = EMIT;
        end else begin
          idle_d  = idle_q + TIM_ONE;
`endif
        end
      end

      COLLECT: begin
        timer_d = timer_q + TIM_ONE;
        if (accept) begin
          count_d = count_q + CNT_ONE;
        end
        // A message accepted on the closing edge is already folded into count_d.
        if (count_d == CNT_MAX || flush || timer_q == TIM_LAST) begin
          state_d = EMIT;
        end
      end

      EMIT: begin
        if (hdr_ready) begin
          state_d = IDLE;
          count_d = '0;
          timer_d = '0;
`ifdef STAGE3_HEARTBEAT_EN
          idle_d  = '0;
          if (count_q != '0) begin
            seq_d = seq_q + SEQ_ONE;
          end
`else
          seq_d   = seq_q + SEQ_ONE;
`endif
        end
      end

      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      seq_q   <= SEQ_RST;
      count_q <= '0;
      timer_q <= '0;
`ifdef STAGE3_HEARTBEAT_EN
      idle_q  <= '0;
`endif
    end else begin
      // NOTE: non-blocking assignments so every register samples pre-edge values together.
      state_q <= state_d;
      seq_q   <= seq_d;
      count_q <= count_d;
      timer_q <= timer_d;
`ifdef STAGE3_HEARTBEAT_EN
      idle_q  <= idle_d;
`endif
    end
  end

endmodule

// File: tb/tb_stage3_packet_seq_ctrl_module.sv
// Directed bench for stage3_packet_seq_ctrl_module (MAX_MSGS=4, TIMEOUT_CYCLES=16, SEQ_INIT=1),
// plus a 4-bit-seq instance for wrap. Inputs change and outputs are sampled on the falling edge.
module tb_stage3_packet_seq_ctrl_module;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        msg_valid, flush, hdr_ready;
  logic        msg_ready, hdr_valid;
  logic [15:0] seq;
  logic [7:0]  msgs;

  logic        rst_w_n;
  logic        w_msg_valid, w_flush, w_hdr_ready;
  logic        w_msg_ready, w_hdr_valid;
  logic [3:0]  w_seq;
  logic [7:0]  w_msgs;

  int tests  = 0;
  int failed = 0;

  always #5 clk = ~clk;

  stage3_packet_seq_ctrl_module #(
    .PACKET_SEQ_NUM_DATA_BITS (16),
    .PACKET_MESSAGES_DATA_BITS(8),
    .MAX_MSGS                 (4),
    .TIMEOUT_CYCLES           (16),
    .SEQ_INIT                 (1)
  ) dut (
    .clk                 (clk),
    .rst_n               (rst_n),
    .msg_valid           (msg_valid),
    .msg_ready           (msg_ready),
    .flush               (flush),
    .hdr_valid           (hdr_valid),
    .hdr_ready           (hdr_ready),
    .packet_seq_num_data (seq),
    .packet_messages_data(msgs)
  );

  stage3_packet_seq_ctrl_module #(
    .PACKET_SEQ_NUM_DATA_BITS (4),
    .PACKET_MESSAGES_DATA_BITS(8),
    .MAX_MSGS                 (4),
    .TIMEOUT_CYCLES           (16),
    .SEQ_INIT                 (15)
  ) dut_w (
    .clk                 (clk),
    .rst_n               (rst_w_n),
    .msg_valid           (w_msg_valid),
    .msg_ready           (w_msg_ready),
    .flush               (w_flush),
    .hdr_valid           (w_hdr_valid),
    .hdr_ready           (w_hdr_ready),
    .packet_seq_num_data (w_seq),
    .packet_messages_data(w_msgs)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      failed++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Bounded wait on the main instance: n = falling edges until hdr_valid, or -1 if none.
  task automatic wait_hdr(input int max_cyc, output int n);
    n = -1;
    for (int i = 1; i <= max_cyc; i++) begin
      @(negedge clk);
      if (hdr_valid === 1'b1) begin
        n = i;
        break;
      end
    end
  endtask

  initial begin
    int   n;
    logic ok;

    rst_n = 1'b0; msg_valid = 1'b0; flush = 1'b0; hdr_ready = 1'b0;
    rst_w_n = 1'b0; w_msg_valid = 1'b0; w_flush = 1'b0; w_hdr_ready = 1'b0;
    repeat (2) @(negedge clk);

    check("rst_msg_ready", msg_ready, 1);
    check("rst_hdr_valid", hdr_valid, 0);
    check("rst_seq",       seq,       1);
    check("rst_msgs",      msgs,      0);
    rst_n = 1'b1;

    // Count limit: four back-to-back messages close the packet.
    msg_valid = 1'b1; hdr_ready = 1'b1;
    repeat (3) @(negedge clk);
    check("cnt_not_yet", hdr_valid, 0);
    @(negedge clk);
    msg_valid = 1'b0;
    check("cnt_hdr_valid", hdr_valid, 1);
    check("cnt_seq",       seq,       1);
    check("cnt_msgs",      msgs,      4);
    check("cnt_msg_ready", msg_ready, 0);
    @(negedge clk);
    check("cnt_one_cycle", hdr_valid, 0);
    check("cnt_ready_back", msg_ready, 1);
    msg_valid = 1'b1;
    repeat (4) @(negedge clk);
    msg_valid = 1'b0;
    check("cnt2_hdr_valid", hdr_valid, 1);
    check("cnt2_seq",       seq,       2);
    check("cnt2_msgs",      msgs,      4);
    @(negedge clk);

    // Flush closes a partial packet; flush alone in IDLE does nothing.
    msg_valid = 1'b1;
    repeat (2) @(negedge clk);
    msg_valid = 1'b0;
    repeat (2) @(negedge clk);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    check("fl_hdr_valid", hdr_valid, 1);
    check("fl_seq",       seq,       3);
    check("fl_msgs",      msgs,      2);
    @(negedge clk);
    check("fl_done", hdr_valid, 0);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    wait_hdr(5, n);
    check("fl_idle_no_hdr", n, -1);
    msg_valid = 1'b1; flush = 1'b1;
    @(negedge clk);
    msg_valid = 1'b0; flush = 1'b0;
    check("fl_msg_hdr_valid", hdr_valid, 1);
    check("fl_msg_seq",       seq,       4);
    check("fl_msg_msgs",      msgs,      1);
    @(negedge clk);

    // Timeout: single message at edge E closes on edge E+16.
    msg_valid = 1'b1;
    @(negedge clk);
    msg_valid = 1'b0;
    ok = 1'b1;
    for (int i = 1; i <= 15; i++) begin
      @(negedge clk);
      if (hdr_valid !== 1'b0) ok = 1'b0;
    end
    check("to_no_early", ok, 1);
    @(negedge clk);
    check("to_hdr_valid", hdr_valid, 1);
    check("to_seq",       seq,       5);
    check("to_msgs",      msgs,      1);
    @(negedge clk);

    // Timeout with a late message on edge E+15: it is included.
    msg_valid = 1'b1;
    @(negedge clk);
    msg_valid = 1'b0;
    repeat (14) @(negedge clk);
    msg_valid = 1'b1;
    @(negedge clk);
    msg_valid = 1'b0;
    check("to2_not_yet",  hdr_valid, 0);
    @(negedge clk);
    check("to2_hdr_valid", hdr_valid, 1);
    check("to2_seq",       seq,       6);
    check("to2_msgs",      msgs,      2);
    @(negedge clk);

    // Backpressure: header held for 10 cycles with messages offered and refused.
    hdr_ready = 1'b0; msg_valid = 1'b1;
    repeat (4) @(negedge clk);
    ok = 1'b1;
    for (int i = 0; i < 10; i++) begin
      if (!(hdr_valid === 1'b1 && seq === 16'd7 && msgs === 8'd4 && msg_ready === 1'b0)) ok = 1'b0;
      @(negedge clk);
    end
    check("bp_stable", ok, 1);
    msg_valid = 1'b0; hdr_ready = 1'b1;
    @(negedge clk);
    check("bp_released",  hdr_valid, 0);
    check("bp_msg_ready", msg_ready, 1);
    msg_valid = 1'b1; flush = 1'b1;
    @(negedge clk);
    msg_valid = 1'b0; flush = 1'b0;
    check("bp_next_seq",  seq,  8);
    check("bp_next_msgs", msgs, 1);
    @(negedge clk);

    // Count limit, flush and timeout on the same edge: one packet only.
    msg_valid = 1'b1;
    repeat (3) @(negedge clk);
    msg_valid = 1'b0;
    repeat (13) @(negedge clk);
    check("sim_not_yet", hdr_valid, 0);
    msg_valid = 1'b1; flush = 1'b1;
    @(negedge clk);
    msg_valid = 1'b0; flush = 1'b0;
    check("sim_hdr_valid", hdr_valid, 1);
    check("sim_seq",       seq,       9);
    check("sim_msgs",      msgs,      4);
    @(negedge clk);
    wait_hdr(5, n);
    check("sim_single", n, -1);

    // Reset mid-packet discards pending messages immediately.
    msg_valid = 1'b1;
    repeat (2) @(negedge clk);
    msg_valid = 1'b0;
    rst_n = 1'b0;
    #1;
    check("mid_rst_seq",       seq,       1);
    check("mid_rst_msgs",      msgs,      0);
    check("mid_rst_msg_ready", msg_ready, 1);
    @(negedge clk);
    rst_n = 1'b1;
    msg_valid = 1'b1; flush = 1'b1;
    @(negedge clk);
    msg_valid = 1'b0; flush = 1'b0;
    check("post_rst_seq",  seq,  1);
    check("post_rst_msgs", msgs, 1);
    @(negedge clk);

    // Idle behaviour from a fresh reset.
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1; hdr_ready = 1'b0;
`ifdef STAGE3_HEARTBEAT_EN
    wait_hdr(20, n);
    check("hb_cycles", n, 16);
    check("hb_seq",    seq,  1);
    check("hb_msgs",   msgs, 0);
    hdr_ready = 1'b1;
    @(negedge clk);
    check("hb_done", hdr_valid, 0);
    msg_valid = 1'b1; flush = 1'b1;
    @(negedge clk);
    msg_valid = 1'b0; flush = 1'b0;
    check("hb_next_seq",  seq,  1);
    check("hb_next_msgs", msgs, 1);
    @(negedge clk);
`else
    wait_hdr(100, n);
    check("no_hb", n, -1);
`endif

    // Seq wrap on the 4-bit instance.
    check("w_rst_seq", w_seq, 15);
    rst_w_n = 1'b1; w_hdr_ready = 1'b1;
    w_msg_valid = 1'b1; w_flush = 1'b1;
    @(negedge clk);
    w_msg_valid = 1'b0; w_flush = 1'b0;
    check("w1_hdr_valid", w_hdr_valid, 1);
    check("w1_seq",       w_seq,       15);
    @(negedge clk);
    w_msg_valid = 1'b1; w_flush = 1'b1;
    @(negedge clk);
    w_msg_valid = 1'b0; w_flush = 1'b0;
    check("w2_hdr_valid", w_hdr_valid, 1);
    check("w2_seq",       w_seq,       0);
    check("w2_msgs",      w_msgs,      1);
    @(negedge clk);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
